// File: rtl/reg_file_sb_if.sv
// reg_file_sb_if -- bus bundle for the scoreboarded register file.
//   Read port A/B : ra_addr/rb_addr in, ra_data/rb_data + ra_rdy/rb_rdy out
//   Writeback     : we, waddr, wdata in (clears the busy bit)
//   Issue         : iss_valid, iss_addr in (sets the busy bit)
//   Clear control : clr_start in, clr_busy/clr_done out
// master = requester side, slave = register file side.
interface reg_file_sb_if #(
  parameter int DATA = 18,
  parameter int ADDR = 5
);
  logic [ADDR-1:0] ra_addr;
  logic [ADDR-1:0] rb_addr;
  logic [DATA-1:0] ra_data;
  logic [DATA-1:0] rb_data;
  logic            ra_rdy;
  logic            rb_rdy;
  logic            we;
  logic [ADDR-1:0] waddr;
  logic [DATA-1:0] wdata;
  logic            iss_valid;
  logic [ADDR-1:0] iss_addr;
  logic            clr_start;
  logic            clr_busy;
  logic            clr_done;

  modport master (
    output ra_addr, rb_addr, we, waddr, wdata, iss_valid, iss_addr, clr_start,
    input  ra_data, rb_data, ra_rdy, rb_rdy, clr_busy, clr_done
  );

  modport slave (
    input  ra_addr, rb_addr, we, waddr, wdata, iss_valid, iss_addr, clr_start,
    output ra_data, rb_data, ra_rdy, rb_rdy, clr_busy, clr_done
  );
endinterface

// File: rtl/reg_file_sb.sv
// reg_file_sb -- 2-read/1-write register file with per-register busy
// (pending writeback) scoreboard and a sequential clear engine.
//   clk   : single clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : reg_file_sb_if.slave (read ports, writeback, issue, clear)
// Reads are registered (1-cycle latency) and write-first. The rdy flags show
// the busy bit after the same cycle's issue/writeback update.
module reg_file_sb #(
  parameter int DATA     = 18,
  parameter int ADDR     = 5,
  parameter int ZERO_REG = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  reg_file_sb_if.slave bus
);

  localparam int unsigned DEPTH = 2 ** ADDR;

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t            state_q;
  logic [ADDR-1:0]   cnt_q;
  logic              done_q;
  logic [DATA-1:0]   mem_q [DEPTH];
  logic [DEPTH-1:0]  busy_q;
  logic [DEPTH-1:0]  busy_d;
  logic [DATA-1:0]   ra_data_q, ra_data_d;
  logic [DATA-1:0]   rb_data_q, rb_data_d;
  logic              ra_rdy_q, ra_rdy_d;
  logic              rb_rdy_q, rb_rdy_d;
  logic              we_eff;
  logic              iss_eff;

  // Register 0 (when hardwired) and the whole CLEAR phase mask both ports.
  always_comb begin
    we_eff  = bus.we && (state_q == IDLE) &&
              !((ZERO_REG != 0) && (bus.waddr == '0));
    iss_eff = bus.iss_valid && (state_q == IDLE) &&
              !((ZERO_REG != 0) && (bus.iss_addr == '0));

    // Issue is applied after writeback so it wins on the same register.
    busy_d = busy_q;
    if (we_eff)  busy_d[bus.waddr]    = 1'b0;
    if (iss_eff) busy_d[bus.iss_addr] = 1'b1;
    if ((state_q == IDLE) && bus.clr_start) busy_d = '0;

    ra_data_d = (we_eff && (bus.waddr == bus.ra_addr)) ? bus.wdata : mem_q[bus.ra_addr];
    rb_data_d = (we_eff && (bus.waddr == bus.rb_addr)) ? bus.wdata : mem_q[bus.rb_addr];
    ra_rdy_d  = !busy_d[bus.ra_addr];
    rb_rdy_d  = !busy_d[bus.rb_addr];
    if (state_q == CLEAR) begin
      ra_data_d = '0;
      rb_data_d = '0;
      ra_rdy_d  = 1'b0;
      rb_rdy_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      done_q    <= 1'b0;
      busy_q    <= '0;
      ra_data_q <= '0;
      rb_data_q <= '0;
      ra_rdy_q  <= 1'b0;
      rb_rdy_q  <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      busy_q    <= busy_d;
      ra_data_q <= ra_data_d;
      rb_data_q <= rb_data_d;
      ra_rdy_q  <= ra_rdy_d;
      rb_rdy_q  <= rb_rdy_d;
      done_q    <= 1'b0;
      if (we_eff) mem_q[bus.waddr] <= bus.wdata;
      case (state_q)
        IDLE: begin
          if (bus.clr_start) begin
            state_q <= CLEAR;
            cnt_q   <= '0;
          end
        end
        CLEAR: begin
          mem_q[cnt_q] <= '0;
          cnt_q        <= cnt_q + ADDR'(1);
          if (cnt_q == '1) begin
            state_q <= IDLE;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.ra_data  = ra_data_q;
  assign bus.rb_data  = rb_data_q;
  assign bus.ra_rdy   = ra_rdy_q;
  assign bus.rb_rdy   = rb_rdy_q;
  assign bus.clr_busy = (state_q == CLEAR);
  assign bus.clr_done = done_q;

endmodule

// File: tb/tb_reg_file_sb.sv
// tb_reg_file_sb -- directed self-checking bench for reg_file_sb
// (DATA=18, ADDR=5, ZERO_REG=1).
module tb_reg_file_sb;

  logic clk = 1'b0;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;
  int   busy_cycles;
  int   done_cnt;

  always #5 clk = ~clk;

  reg_file_sb_if #(.DATA(18), .ADDR(5)) bus ();

  reg_file_sb #(.DATA(18), .ADDR(5), .ZERO_REG(1)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n         = 1'b1;
    bus.ra_addr   = '0;
    bus.rb_addr   = '0;
    bus.we        = 1'b0;
    bus.waddr     = '0;
    bus.wdata     = '0;
    bus.iss_valid = 1'b0;
    bus.iss_addr  = '0;
    bus.clr_start = 1'b0;

    // Reset state, before any clock edge
    #1 rst_n = 1'b0;
    #2;
    check("rst_ra_data", 32'(bus.ra_data), 0);
    check("rst_ra_rdy",  32'(bus.ra_rdy), 0);
    check("rst_rb_rdy",  32'(bus.rb_rdy), 0);
    check("rst_clr_busy", 32'(bus.clr_busy), 0);
    check("rst_clr_done", 32'(bus.clr_done), 0);
    #9 rst_n = 1'b1;

    // First read after reset
    bus.ra_addr = 5'd3;
    bus.rb_addr = 5'd0;
    tick();
    check("first_ra_data", 32'(bus.ra_data), 0);
    check("first_ra_rdy",  32'(bus.ra_rdy), 1);
    check("first_rb_rdy",  32'(bus.rb_rdy), 1);

    // Plain write then read
    bus.we = 1'b1; bus.waddr = 5'd7; bus.wdata = 18'h2ABCD;
    tick();
    bus.we = 1'b0; bus.ra_addr = 5'd7;
    tick();
    check("wr7_ra_data", 32'(bus.ra_data), 32'h2ABCD);
    check("wr7_ra_rdy",  32'(bus.ra_rdy), 1);

    // Write-first bypass on port B
    bus.we = 1'b1; bus.waddr = 5'd9; bus.wdata = 18'h00123; bus.rb_addr = 5'd9;
    tick();
    bus.we = 1'b0;
    check("byp9_rb_data", 32'(bus.rb_data), 32'h00123);
    check("byp9_rb_rdy",  32'(bus.rb_rdy), 1);

    // Issue sets busy, it persists, writeback clears it with bypassed data
    bus.iss_valid = 1'b1; bus.iss_addr = 5'd12; bus.ra_addr = 5'd12;
    tick();
    check("iss12_rdy", 32'(bus.ra_rdy), 0);
    bus.iss_valid = 1'b0;
    tick();
    check("iss12_hold_rdy", 32'(bus.ra_rdy), 0);
    bus.we = 1'b1; bus.waddr = 5'd12; bus.wdata = 18'h00555;
    tick();
    bus.we = 1'b0;
    check("wb12_data", 32'(bus.ra_data), 32'h00555);
    check("wb12_rdy",  32'(bus.ra_rdy), 1);

    // Issue and writeback to the same register: data lands, busy stays set
    bus.iss_valid = 1'b1; bus.iss_addr = 5'd4;
    bus.we = 1'b1; bus.waddr = 5'd4; bus.wdata = 18'h1F00F; bus.ra_addr = 5'd4;
    tick();
    bus.iss_valid = 1'b0; bus.we = 1'b0;
    check("isswb4_data", 32'(bus.ra_data), 32'h1F00F);
    check("isswb4_rdy",  32'(bus.ra_rdy), 0);
    tick();
    check("isswb4_rd_data", 32'(bus.ra_data), 32'h1F00F);
    check("isswb4_rd_rdy",  32'(bus.ra_rdy), 0);

    // Hardwired register 0
    bus.we = 1'b1; bus.waddr = 5'd0; bus.wdata = 18'h3FFFF; bus.ra_addr = 5'd0;
    tick();
    bus.we = 1'b0;
    check("r0_wr_data", 32'(bus.ra_data), 0);
    check("r0_wr_rdy",  32'(bus.ra_rdy), 1);
    bus.iss_valid = 1'b1; bus.iss_addr = 5'd0;
    tick();
    bus.iss_valid = 1'b0;
    check("r0_iss_rdy",  32'(bus.ra_rdy), 1);
    check("r0_iss_data", 32'(bus.ra_data), 0);

    // Both ports on one register
    bus.ra_addr = 5'd7; bus.rb_addr = 5'd7;
    tick();
    check("dual7_ra", 32'(bus.ra_data), 32'h2ABCD);
    check("dual7_rb", 32'(bus.rb_data), 32'h2ABCD);

    // Fill 1..31 with nonzero data, leave reg 20 busy
    for (int i = 1; i < 32; i++) begin
      bus.we = 1'b1; bus.waddr = 5'(i); bus.wdata = 18'(i * 1031 + 1);
      tick();
    end
    bus.we = 1'b0;
    bus.iss_valid = 1'b1; bus.iss_addr = 5'd20;
    tick();
    bus.iss_valid = 1'b0;
    bus.ra_addr = 5'd31;
    tick();
    check("fill31_data", 32'(bus.ra_data), 32'(18'(31 * 1031 + 1)));

    // Sequential clear: writes/issues and a second clr_start are ignored
    bus.clr_start = 1'b1;
    tick();
    bus.clr_start = 1'b0;
    bus.we = 1'b1; bus.waddr = 5'd5; bus.wdata = 18'h3AAAA;
    bus.iss_valid = 1'b1; bus.iss_addr = 5'd6;
    busy_cycles = 0;
    done_cnt    = 0;
    for (int k = 0; k < 40; k++) begin
      if (bus.clr_busy) busy_cycles++;
      if (bus.clr_done) begin
        done_cnt++;
        check("clr_done_busy_low", 32'(bus.clr_busy), 0);
      end
      if (k == 5) begin
        check("clr_ra_data", 32'(bus.ra_data), 0);
        check("clr_ra_rdy",  32'(bus.ra_rdy), 0);
      end
      if (k == 10) bus.clr_start = 1'b1;
      if (k == 11) bus.clr_start = 1'b0;
      if (k == 30) begin
        bus.we = 1'b0;
        bus.iss_valid = 1'b0;
      end
      tick();
    end
    check("clr_busy_cycles", 32'(busy_cycles), 32);
    check("clr_done_pulses", 32'(done_cnt), 1);
    for (int i = 0; i < 32; i++) begin
      bus.ra_addr = 5'(i); bus.rb_addr = 5'(31 - i);
      tick();
      check($sformatf("clr_ra_data_%0d", i), 32'(bus.ra_data), 0);
      check($sformatf("clr_ra_rdy_%0d", i),  32'(bus.ra_rdy), 1);
      check($sformatf("clr_rb_data_%0d", 31 - i), 32'(bus.rb_data), 0);
    end

    // Reset in the middle of a clear (counter at 10)
    bus.we = 1'b1; bus.waddr = 5'd3; bus.wdata = 18'h01234; bus.ra_addr = 5'd3;
    tick();
    bus.we = 1'b0;
    check("pre_abort_data", 32'(bus.ra_data), 32'h01234);
    bus.clr_start = 1'b1;
    tick();
    bus.clr_start = 1'b0;
    repeat (10) tick();
    check("abort_busy_before", 32'(bus.clr_busy), 1);
    #2 rst_n = 1'b0;
    #1;
    check("abort_clr_busy", 32'(bus.clr_busy), 0);
    check("abort_clr_done", 32'(bus.clr_done), 0);
    check("abort_ra_data",  32'(bus.ra_data), 0);
    check("abort_ra_rdy",   32'(bus.ra_rdy), 0);
    #3 rst_n = 1'b1;
    busy_cycles = 0;
    done_cnt    = 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (bus.clr_busy) busy_cycles++;
      if (bus.clr_done) done_cnt++;
    end
    check("abort_busy_after", 32'(busy_cycles), 0);
    check("abort_no_done",    32'(done_cnt), 0);
    for (int i = 0; i < 32; i++) begin
      bus.ra_addr = 5'(i);
      tick();
      check($sformatf("abort_ra_data_%0d", i), 32'(bus.ra_data), 0);
      check($sformatf("abort_ra_rdy_%0d", i),  32'(bus.ra_rdy), 1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/reg_file_sb.md
REG_FILE_SB -- requirements
Module: reg_file_sb

Interface
REQ-001 Parameter DATA, default 18, SHALL set the register width in bits.
REQ-002 Parameter ADDR, default 5, SHALL set the address width; depth = 2**ADDR registers.
REQ-003 Parameter ZERO_REG, default 1, SHALL hardwire register 0 to zero when set: reads 0, never busy, writes and issues ignored.
REQ-004 Port clk, input, 1, SHALL be the single clock; all state updates on its rising edge.
REQ-005 Port rst_n, input, 1, SHALL be the reset: asynchronous, active-low.
REQ-006 Ports ra_addr and rb_addr, input, ADDR each, SHALL be the read addresses for ports A and B.
REQ-007 Ports ra_data and rb_data, output, DATA each, SHALL be the registered read data.
REQ-008 Ports ra_rdy and rb_rdy, output, 1 each, SHALL be high when the read register has no pending writeback.
REQ-009 Ports we, waddr (ADDR) and wdata (DATA), input, SHALL form the writeback port.
REQ-010 Ports iss_valid and iss_addr (ADDR), input, SHALL mark a destination register busy (pending writeback).
REQ-011 Port clr_start, input, 1, SHALL request a sequential clear of all registers.
REQ-012 Port clr_busy, output, 1, SHALL be high while a clear is in progress.
REQ-013 Port clr_done, output, 1, SHALL pulse high for one cycle when a clear completes.

Function
REQ-014 Read latency SHALL be 1 cycle: the address sampled at edge N produces data and rdy valid after edge N.
REQ-015 Reads SHALL be write-first: if we=1 and waddr equals a read address in the same cycle, that port SHALL return wdata.
REQ-016 Both read ports and the write port SHALL operate every cycle; A and B may address the same register.
REQ-017 A busy bit per register SHALL be set by iss_valid at iss_addr and cleared by we at waddr.
REQ-018 If iss_valid and we target the same register in the same cycle, the busy bit SHALL end set: the issue wins.
REQ-019 The rdy outputs SHALL reflect the busy bit after that cycle's update: same-cycle issue gives rdy=0; same-cycle writeback without issue gives rdy=1.
REQ-020 The FSM SHALL have two states, IDLE and CLEAR.
REQ-021 IDLE to CLEAR SHALL occur on clr_start=1; this SHALL zero all busy bits and load the clear counter with 0.
REQ-022 In CLEAR, one register per cycle SHALL be written 0, at counter value 0 .. 2**ADDR-1; the counter increments by 1.
REQ-023 After the write of address 2**ADDR-1, the FSM SHALL return to IDLE and assert clr_done for that one cycle; a clear SHALL take exactly 2**ADDR cycles.
REQ-024 In CLEAR, we and iss_valid SHALL be ignored, rdy outputs SHALL be 0, and data outputs SHALL be 0.
REQ-025 clr_start asserted while in CLEAR SHALL be ignored; the counter SHALL NOT restart.
REQ-026 clr_busy SHALL equal (state == CLEAR).

Reset
REQ-027 With rst_n=0, all registers, all busy bits, ra_data and rb_data SHALL be 0, immediately and independent of clk.
REQ-028 With rst_n=0, ra_rdy, rb_rdy, clr_busy and clr_done SHALL be 0, the FSM SHALL be IDLE and the counter 0.
REQ-029 Reset asserted during CLEAR SHALL abort the clear; after release the FSM SHALL be IDLE with no clr_done pulse.
REQ-030 The first read after reset release SHALL return data 0 with rdy=1.

Verification
REQ-031 Write 0x2ABCD to reg 7, then read A=7 the next cycle -> ra_data=0x2ABCD, ra_rdy=1 one cycle later.
REQ-032 In one cycle, we=1 to reg 9 with 0x00123 and rb_addr=9 -> rb_data=0x00123 after that edge (bypass).
REQ-033 In one cycle, iss_valid to reg 4 and we to reg 4 -> reg 4 holds the new data, and ra_rdy=0 on a following read of reg 4.
REQ-034 Write reg 0 with 0x3FFFF (ZERO_REG=1), then read reg 0 -> data 0, rdy=1; iss_valid to reg 0 -> rdy stays 1.
REQ-035 Fill regs with nonzero data, pulse clr_start -> clr_busy high 32 cycles, clr_done one pulse, all 32 regs read 0, and writes during CLEAR are lost.
REQ-036 Drop rst_n mid-CLEAR, at counter 10 -> outputs 0 asynchronously; after release, clr_busy=0, no clr_done, all regs read 0.
